// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM state codes, port owner
// and the default starvation allowance.
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t WAIT  = 2'd2;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int unsigned STARVE_LIM_DEFAULT = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  // Data normally wins; a fetch that has used up its waiting allowance takes the port.
  function automatic owner_t pick_owner(input logic fetch_req,
                                        input logic data_req,
                                        input logic fetch_starved);
    owner_t owner;
    if (data_req && !(fetch_req && fetch_starved)) owner = DATA;
    else owner = FETCH;
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data-access requesters onto one shared memory
// port with a single outstanding transaction (IDLE -> ISSUE -> WAIT).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_f,
  input  logic [31:0] if_addr_f,
  input  logic        if_flush,
  output logic        if_ready_f,
  output logic [31:0] if_rdata_f,
  input  logic        dm_req_m,
  input  logic        dm_we_m,
  input  logic [31:0] dm_addr_m,
  input  logic [31:0] dm_wdata_m,
  input  logic [3:0]  dm_be_m,
  output logic        dm_ready_m,
  output logic [31:0] dm_rdata_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        mem_stall
);

  localparam int unsigned CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

  arb_state_t       state_reg, state_next;
  owner_t           owner_reg, owner_next;
  bus_req_t         bus_reg, bus_next;
  logic             req_reg, req_next;
  logic             discard_reg, discard_next;
  logic [CNT_W-1:0] starve_reg, starve_next;

  logic     any_req;
  logic     arbitrate;
  logic     fetch_starved;
  logic     resp_done;
  logic     fetch_owns;
  logic     fetch_done;
  logic     data_done;
  owner_t   grant_owner;
  bus_req_t fetch_fields;
  bus_req_t data_fields;

  assign any_req       = if_req_f | dm_req_m;
  assign arbitrate     = (state_reg == IDLE) && any_req;
  assign fetch_starved = (starve_reg == STARVE_MAX);
  assign grant_owner   = pick_owner(if_req_f, dm_req_m, fetch_starved);
  assign resp_done     = (state_reg == WAIT) && mem_rvalid;
  assign fetch_owns    = (owner_reg == FETCH) && ((state_reg == ISSUE) || (state_reg == WAIT));

  // Fetches are full-word reads.
  assign fetch_fields = '{we: 1'b0, addr: if_addr_f, wdata: 32'd0, be: 4'hF};
  assign data_fields  = '{we: dm_we_m, addr: dm_addr_m, wdata: dm_wdata_m, be: dm_be_m};

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    bus_next   = bus_reg;
    req_next   = req_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
          owner_next = grant_owner;
          bus_next   = (grant_owner == DATA) ? data_fields : fetch_fields;
          req_next   = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_next = WAIT;
          req_next   = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // A flushed fetch still finishes on the bus; only its completion is hidden.
  always_comb begin
    discard_next = discard_reg;
    if (state_next == IDLE) discard_next = 1'b0;
    else if (fetch_owns && if_flush) discard_next = 1'b1;
  end

  always_comb begin
    starve_next = starve_reg;
    if (!if_req_f) begin
      starve_next = '0;
    end else if (arbitrate) begin
      if (grant_owner == FETCH) starve_next = '0;
      else if (!fetch_starved) starve_next = starve_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= FETCH;
      bus_reg     <= '0;
      req_reg     <= 1'b0;
      discard_reg <= 1'b0;
      starve_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      bus_reg     <= bus_next;
      req_reg     <= req_next;
      discard_reg <= discard_next;
      starve_reg  <= starve_next;
    end
  end

  // A flush arriving in the response cycle also hides that fetch's completion.
  assign fetch_done = resp_done && (owner_reg == FETCH) && !discard_reg && !if_flush;
  assign data_done  = resp_done && (owner_reg == DATA);

  assign if_ready_f = fetch_done;
  assign if_rdata_f = fetch_done ? mem_rdata : 32'd0;
  assign dm_ready_m = data_done;
  assign dm_rdata_m = data_done ? mem_rdata : 32'd0;

  assign mem_req   = req_reg;
  assign mem_we    = bus_reg.we;
  assign mem_addr  = bus_reg.addr;
  assign mem_wdata = bus_reg.wdata;
  assign mem_be    = bus_reg.be;

  assign mem_stall = (if_req_f & ~if_ready_f) | (dm_req_m & ~dm_ready_m);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_f, if_flush, dm_req_m, dm_we_m, mem_gnt, mem_rvalid;
  logic [31:0] if_addr_f, dm_addr_m, dm_wdata_m, mem_rdata;
  logic [3:0]  dm_be_m;
  logic        if_ready_f, dm_ready_m, mem_req, mem_we, mem_stall;
  logic [31:0] if_rdata_f, dm_rdata_m, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int txns = 0;
  int req_cycles;
  bit f_act, d_act;

  // Model of the single outstanding transaction.
  bit          m_busy, m_acc, m_disc, m_data, m_fetch_fields;
  int          m_starve;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  mem_port_arbiter #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_f(if_req_f), .if_addr_f(if_addr_f), .if_flush(if_flush),
    .if_ready_f(if_ready_f), .if_rdata_f(if_rdata_f),
    .dm_req_m(dm_req_m), .dm_we_m(dm_we_m), .dm_addr_m(dm_addr_m),
    .dm_wdata_m(dm_wdata_m), .dm_be_m(dm_be_m),
    .dm_ready_m(dm_ready_m), .dm_rdata_m(dm_rdata_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req_f = 1'b0; if_addr_f = 32'd0; if_flush = 1'b0;
    dm_req_m = 1'b0; dm_we_m = 1'b0; dm_addr_m = 32'd0; dm_wdata_m = 32'd0; dm_be_m = 4'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  // Every cycle: outputs follow from the outstanding transaction and this cycle's inputs;
  // then the model advances to what the coming edge must produce.
  always @(negedge clk) begin : compare
    bit resp, e_if, e_dm, take_data;
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_disc = 0; m_data = 0; m_fetch_fields = 0; m_starve = 0;
      m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0;
      chk("rst_mem_req", mem_req, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", mem_be, 32'd0);
      chk("rst_mem_we", mem_we, 32'd0);
      chk("rst_if_ready", if_ready_f, 32'd0);
      chk("rst_dm_ready", dm_ready_m, 32'd0);
    end else begin
      resp = m_busy && m_acc && mem_rvalid;
      e_if = resp && !m_data && !m_disc && !if_flush;
      e_dm = resp && m_data;
      chk("if_ready_f", if_ready_f, e_if);
      chk("if_rdata_f", if_rdata_f, e_if ? mem_rdata : 32'd0);
      chk("dm_ready_m", dm_ready_m, e_dm);
      chk("dm_rdata_m", dm_rdata_m, e_dm ? mem_rdata : 32'd0);
      chk("mem_req", mem_req, m_busy && !m_acc);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (!m_fetch_fields) begin
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_be", mem_be, m_be);
      end
      chk("mem_stall", mem_stall, (if_req_f && !e_if) || (dm_req_m && !e_dm));
      if (resp) begin
        txns++;
        $display("txn %0d %s addr=0x%h we=%0d rdata=0x%h%s", txns, m_data ? "DATA " : "FETCH",
                 m_addr, m_we, mem_rdata, (!m_data && !e_if) ? " (discarded)" : "");
      end

      if (!m_busy) begin
        if (if_req_f || dm_req_m) begin
          take_data = dm_req_m && !(if_req_f && m_starve == LIM);
          m_busy = 1; m_acc = 0; m_disc = 0; m_data = take_data;
          if (take_data) begin
            m_we = dm_we_m; m_addr = dm_addr_m; m_wdata = dm_wdata_m; m_be = dm_be_m;
            m_fetch_fields = 0;
          end else begin
            m_we = 1'b0; m_addr = if_addr_f; m_fetch_fields = 1;
          end
          if (if_req_f) m_starve = take_data ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        end
      end else if (!m_acc) begin
        if (!m_data && if_flush) m_disc = 1;
        if (mem_gnt) m_acc = 1;
      end else if (mem_rvalid) begin
        m_busy = 0; m_disc = 0;
      end else if (!m_data && if_flush) begin
        m_disc = 1;
      end
      if (!if_req_f) m_starve = 0;
    end
  end

  initial begin
    idle_inputs();
    mid();
    chk("reset_mem_req", mem_req, 32'd0);
    chk("reset_if_ready", if_ready_f, 32'd0);
    mid();
    cyc();
    rst_n = 1'b1;

    // Lone fetch, gnt in cycle 2, rvalid in cycle 3.
    if_req_f = 1'b1; if_addr_f = 32'h100;
    mid(); chk("fetch_c1_mem_req", mem_req, 32'd0); cyc();
    mem_gnt = 1'b1;
    mid(); chk("fetch_c2_mem_req", mem_req, 32'd1); chk("fetch_c2_addr", mem_addr, 32'h100); cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    mid(); chk("fetch_c3_ready", if_ready_f, 32'd1); chk("fetch_c3_rdata", if_rdata_f, 32'h00500093); cyc();
    idle_inputs();
    mid(); chk("fetch_c4_ready", if_ready_f, 32'd0); cyc();

    // Both request together: data first, then fetch.
    if_req_f = 1'b1; if_addr_f = 32'h104;
    dm_req_m = 1'b1; dm_we_m = 1'b0; dm_addr_m = 32'h2000; dm_be_m = 4'hF;
    mid(); cyc();
    mem_gnt = 1'b1;
    mid(); chk("both_first_addr", mem_addr, 32'h2000); chk("both_first_we", mem_we, 32'd0); cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    mid();
    chk("both_dm_ready", dm_ready_m, 32'd1); chk("both_dm_rdata", dm_rdata_m, 32'h12345678);
    chk("both_if_idle", if_ready_f, 32'd0);
    cyc();
    dm_req_m = 1'b0; mem_rvalid = 1'b0;
    mid(); cyc();
    mem_gnt = 1'b1;
    mid(); chk("both_second_req", mem_req, 32'd1); chk("both_second_addr", mem_addr, 32'h104); cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    mid(); chk("both_if_ready", if_ready_f, 32'd1); cyc();
    idle_inputs();
    mid(); cyc();

    // Data held with fetch waiting: grant 5 must go to fetch.
    if_req_f = 1'b1; if_addr_f = 32'h200;
    dm_req_m = 1'b1; dm_we_m = 1'b0; dm_addr_m = 32'h3000; dm_be_m = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      mid(); cyc();
      mem_gnt = 1'b1;
      mid(); chk($sformatf("starve_grant%0d", k), mem_addr, (k == 5) ? 32'h200 : 32'h3000); cyc();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0 + k;
      mid(); cyc();
      mem_rvalid = 1'b0;
    end
    idle_inputs();
    mid(); cyc();

    // Flush during fetch WAIT; rvalid two cycles later is swallowed.
    if_req_f = 1'b1; if_addr_f = 32'h300;
    mid(); cyc();
    mem_gnt = 1'b1; mid(); cyc();
    mem_gnt = 1'b0; if_flush = 1'b1; mid(); cyc();
    if_flush = 1'b0; if_addr_f = 32'h400; mid(); cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    mid(); chk("flush_no_ready", if_ready_f, 32'd0); chk("flush_no_rdata", if_rdata_f, 32'd0); cyc();
    mem_rvalid = 1'b0;
    mid(); chk("flush_idle_req", mem_req, 32'd0); cyc();
    mem_gnt = 1'b1;
    mid(); chk("flush_new_req", mem_req, 32'd1); chk("flush_new_addr", mem_addr, 32'h400); cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A00113;
    mid(); chk("flush_new_ready", if_ready_f, 32'd1); cyc();
    idle_inputs();
    mid(); cyc();

    // Store with gnt held off for 3 cycles.
    dm_req_m = 1'b1; dm_we_m = 1'b1; dm_addr_m = 32'h4000; dm_wdata_m = 32'hDEADBEEF; dm_be_m = 4'hF;
    mid(); cyc();
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      mid();
      if (mem_req) req_cycles++;
      chk("store_addr", mem_addr, 32'h4000); chk("store_wdata", mem_wdata, 32'hDEADBEEF);
      chk("store_be", mem_be, 32'hF); chk("store_we", mem_we, 32'd1);
      cyc();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'd0;
    mid();
    chk("store_req_cycles", req_cycles, 32'd4); chk("store_req_low", mem_req, 32'd0);
    chk("store_ready", dm_ready_m, 32'd1);
    cyc();
    idle_inputs();
    mid(); chk("store_ready_after", dm_ready_m, 32'd0); cyc();

    // Reset in WAIT, then a stray rvalid.
    if_req_f = 1'b1; if_addr_f = 32'h500;
    mid(); cyc();
    mem_gnt = 1'b1; mid(); cyc();
    mem_gnt = 1'b0; mid();
    #2;
    if_req_f = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000; rst_n = 1'b0;
    #1;
    chk("rstwait_mem_req", mem_req, 32'd0); chk("rstwait_addr", mem_addr, 32'd0);
    chk("rstwait_be", mem_be, 32'd0); chk("rstwait_if_ready", if_ready_f, 32'd0);
    chk("rstwait_dm_ready", dm_ready_m, 32'd0); chk("rstwait_stall", mem_stall, 32'd0);
    mid(); cyc();
    rst_n = 1'b1;
    mid(); chk("stray_if_ready", if_ready_f, 32'd0); chk("stray_mem_req", mem_req, 32'd0); cyc();
    idle_inputs();
    mid(); cyc();

    // Randomized traffic; requesters hold a request until served (fetch drops on flush).
    f_act = 0; d_act = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!f_act && $urandom_range(0, 3) != 0) begin
        f_act = 1; if_addr_f = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_act && $urandom_range(0, 3) != 0) begin
        d_act = 1; dm_we_m = 1'($urandom_range(0, 1)); dm_addr_m = $urandom;
        dm_wdata_m = $urandom; dm_be_m = 4'($urandom_range(0, 15));
      end
      if_req_f = f_act; dm_req_m = d_act;
      if_flush = ($urandom_range(0, 11) == 0);
      mem_gnt = ($urandom_range(0, 2) != 0);
      mem_rvalid = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      mid();
      if (if_ready_f || if_flush) f_act = 0;
      if (dm_ready_m) d_act = 0;
      cyc();
    end
    idle_inputs();
    mid(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4, is the number of consecutive data grants allowed while fetch waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req_f  input  1  fetch stage requests an instruction word.
REQ-005 if_addr_f  input  32  fetch byte address.
REQ-006 if_flush  input  1  branch/jump taken (PCSrc_e); the outstanding fetch is discarded.
REQ-007 if_ready_f  output  1  one-cycle pulse: if_rdata_f valid, fetch done.
REQ-008 if_rdata_f  output  32  instruction word.
REQ-009 dm_req_m  input  1  memory stage requests a data access.
REQ-010 dm_we_m  input  1  1 = store, 0 = load.
REQ-011 dm_addr_m  input  32  data byte address.
REQ-012 dm_wdata_m  input  32  store data.
REQ-013 dm_be_m  input  4  store byte enables.
REQ-014 dm_ready_m  output  1  one-cycle pulse: access done; dm_rdata_m valid for loads.
REQ-015 dm_rdata_m  output  32  load data.
REQ-016 mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  output  shared-port request, all registered.
REQ-017 mem_gnt  input  1  memory accepts the request in the current cycle.
REQ-018 mem_rvalid  input  1  response/ack for the accepted request (loads and stores).
REQ-019 mem_rdata  input  32  response data.
REQ-020 mem_stall  output  1  (if_req_f & ~if_ready_f) | (dm_req_m & ~dm_ready_m); feeds pipeline stall logic.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE and WAIT, and SHALL allow one outstanding transaction.
REQ-022 In IDLE, with any request pending, the block SHALL latch the owner (FETCH/DATA) and its request fields, and SHALL go to ISSUE; mem_req SHALL be high from the next cycle.
REQ-023 Priority SHALL be: DATA over FETCH, except that FETCH wins when starve_cnt == STARVE_LIM.
REQ-024 starve_cnt SHALL increment (saturating at STARVE_LIM) on each DATA grant while if_req_f=1, and SHALL clear on any FETCH grant or when if_req_f=0.
REQ-025 In ISSUE, mem_req and the fields SHALL hold stable until mem_gnt=1, then the block SHALL go to WAIT with mem_req deasserted.
REQ-026 In WAIT, on mem_rvalid=1 the block SHALL pulse the owner's ready for that cycle, with rdata passed through from mem_rdata, and return to IDLE.
REQ-027 Minimum latency SHALL be 3 cycles from request to ready (IDLE, ISSUE with gnt, WAIT with rvalid); the next arbitration SHALL occur in the cycle after ready.
REQ-028 An if_flush while FETCH owns ISSUE or WAIT SHALL set a discard flag; the transaction SHALL complete on the bus, and if_ready_f SHALL NOT pulse for it.
REQ-029 The discard flag SHALL clear on return to IDLE; an if_flush in IDLE SHALL have no effect.
REQ-030 An if_flush SHALL NOT affect a DATA transaction.
REQ-031 The inactive requester's ready SHALL stay 0; if_rdata_f and dm_rdata_m SHALL be 0 when not ready.
REQ-032 mem_rvalid outside WAIT SHALL be ignored.
REQ-033 mem_gnt outside ISSUE SHALL be ignored.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr/wdata/be=0, starve_cnt=0, discard=0, and both readys 0, including mid-transaction; any in-flight response after reset release SHALL be ignored per REQ-032.

Structure
REQ-035 A shared package SHALL hold arb_state_t (IDLE, ISSUE, WAIT), owner_t (FETCH, DATA) and the default STARVE_LIM constant.
REQ-036 The block SHALL be a single module with no sub-module.

Verification
REQ-037 Fetch only at 0x100, gnt same cycle, rvalid next cycle with rdata=0x00500093 -> if_ready_f pulses at cycle 3 with 0x00500093.
REQ-038 if_req_f and dm_req_m (load 0x2000) both high in IDLE -> DATA granted first, dm_ready_m pulses, then FETCH is issued.
REQ-039 dm_req_m held high for 6 back-to-back accesses with if_req_f high, STARVE_LIM=4 -> the 5th grant goes to FETCH.
REQ-040 if_flush during FETCH WAIT, rvalid 2 cycles later -> no if_ready_f pulse, IDLE next cycle, new fetch accepted.
REQ-041 Store with mem_gnt delayed 3 cycles -> mem_addr, wdata and be=4'b1111 held stable, mem_req high 4 cycles, dm_ready_m pulses on rvalid.
REQ-042 rst_n asserted in WAIT -> all outputs 0 immediately; a later stray mem_rvalid produces no ready.
